// File: rtl/aes128_host_ctrl.sv
// Host-side initiator for the AES128 core: key/mode load, credit-limited block issue, result FIFO.
// Optional watchdog enabled by defining AES_HOST_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no valid key; waiting for cfg_load
// KEY_REQ  | one-cycle aes_en pulse to start key expansion
// KEY_GAP  | one cycle to let a stale aes_rk_ready fall
// KEY_WAIT | waiting for aes_rk_ready
// READY    | round keys valid; blocks may be issued
// DRAIN    | re-key requested; waiting for in-flight blocks to return
module aes128_host_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         cfg_load,
   input  logic [127:0] cfg_key,
   input  logic         cfg_decrypt,
   output logic         cfg_ready,
   output logic         key_ok,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         aes_en,
   output logic [127:0] aes_key,
   output logic         aes_slt,
   output logic         aes_din_valid,
   output logic [127:0] aes_din,
   input  logic         aes_rk_ready,
   input  logic         aes_dout_valid,
   input  logic [127:0] aes_dout,
   output logic         err_ovf,
   output logic         err_timeout
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("aes128_host_ctrl: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {IDLE, KEY_REQ, KEY_GAP, KEY_WAIT, READY, DRAIN} state_t;

   state_t         state;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  fifo_count;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [127:0]   mem [FIFO_DEPTH];
   logic [CW:0]    load;
   logic           credit, hs, pop, push, full, cfg_acc, wd_fire;

   // Blocks in the core plus blocks buffered must fit the FIFO: the core cannot be stalled.
   assign load    = {1'b0, inflight} + {1'b0, fifo_count};
   assign credit  = load < (CW+1)'(FIFO_DEPTH);
   assign s_ready = (state == READY) && credit;
   assign hs      = s_valid && s_ready;
   assign full    = fifo_count == CW'(FIFO_DEPTH);
   assign m_valid = fifo_count != '0;
   assign m_data  = mem[rd_ptr];
   assign pop     = m_valid && m_ready;
   assign push    = aes_dout_valid && (!full || pop);
   assign cfg_acc = cfg_load && cfg_ready;

`ifdef AES_HOST_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wd_cnt;
   state_t        wd_state;
   logic          wd_active, wd_reload;

   // The reload cycle itself counts as the first watched cycle, hence the -2.
   assign wd_active = (state == KEY_WAIT) || ((state == READY || state == DRAIN) && inflight != '0);
   assign wd_reload = !wd_active || aes_dout_valid || (state != wd_state);
   assign wd_fire   = wd_active && !wd_reload && (wd_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_cnt   <= TW'(TIMEOUT_CYCLES - 2);
         wd_state <= IDLE;
      end else begin
         wd_state <= state;
         if (wd_reload)
            wd_cnt <= TW'(TIMEOUT_CYCLES - 2);
         else if (wd_cnt != '0)
            wd_cnt <= wd_cnt - TW'(1);
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         cfg_ready     <= 1'b0;
         key_ok        <= 1'b0;
         aes_en        <= 1'b0;
         aes_key       <= '0;
         aes_slt       <= 1'b0;
         aes_din_valid <= 1'b0;
         aes_din       <= '0;
         inflight      <= '0;
         err_timeout   <= 1'b0;
      end else begin
         aes_en        <= 1'b0;
         aes_din_valid <= hs;
         if (hs)
            aes_din <= s_data;

         if (hs && !(aes_dout_valid && inflight != '0))
            inflight <= inflight + CW'(1);
         else if (!hs && aes_dout_valid && inflight != '0)
            inflight <= inflight - CW'(1);

         case (state)
            IDLE: begin
               cfg_ready <= 1'b1;
               if (cfg_acc) begin
                  aes_key   <= cfg_key;
                  aes_slt   <= cfg_decrypt;
                  cfg_ready <= 1'b0;
                  aes_en    <= 1'b1;
                  state     <= KEY_REQ;
               end
            end
            KEY_REQ: state <= KEY_GAP;
            KEY_GAP: state <= KEY_WAIT;
            KEY_WAIT: begin
               if (aes_rk_ready) begin
                  key_ok    <= 1'b1;
                  cfg_ready <= 1'b1;
                  state     <= READY;
               end
            end
            READY: begin
               if (cfg_acc) begin
                  aes_key   <= cfg_key;
                  aes_slt   <= cfg_decrypt;
                  cfg_ready <= 1'b0;
                  key_ok    <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  aes_en <= 1'b1;
                  state  <= KEY_REQ;
               end
            end
            default: state <= IDLE;
         endcase

         if (wd_fire) begin
            err_timeout <= 1'b1;
            inflight    <= '0;
            cfg_ready   <= 1'b1;
            key_ok      <= 1'b0;
            aes_en      <= 1'b0;
            state       <= IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++)
            mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         err_ovf    <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= aes_dout;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CW'(1);
         if (aes_dout_valid && full && !pop)
            err_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes128_host_ctrl.sv
// Scoreboard bench for aes128_host_ctrl with a behavioural AES core stand-in.
module tb_aes128_host_ctrl;

   localparam logic [127:0] KEY1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] D1   = 128'hd7e5dbd3324595f8fdc7d7c571da6c2a;
   localparam logic [127:0] R1   = 128'h525a0bb6f6626e941a81cd7b5fe8b620;
   localparam logic [127:0] D2   = 128'ha2f4dbd3324595f8fdc7d7c571da6c2b;
   localparam logic [127:0] R2   = 128'hd73f13dadea97657531d06d240c2c627;
   localparam int LAT = 5;

   logic clk = 1'b0, rstn = 1'b0;
   logic cfg_load = 1'b0, cfg_decrypt = 1'b0, cfg_ready, key_ok;
   logic [127:0] cfg_key = '0;
   logic s_valid = 1'b0, s_ready;
   logic [127:0] s_data = '0;
   logic m_valid, m_ready = 1'b0;
   logic [127:0] m_data;
   logic aes_en, aes_slt, aes_din_valid;
   logic [127:0] aes_key, aes_din;
   logic aes_rk_ready = 1'b1, aes_dout_valid = 1'b0;
   logic [127:0] aes_dout = '0;
   logic err_ovf, err_timeout;

   int n_checks = 0, n_fail = 0;
   int en_cycles = 0;
   logic [127:0] exp_q[$];
   bit core_on = 1'b1;

   always #5 clk = ~clk;

   aes128_host_ctrl dut (
      .clk(clk), .rstn(rstn),
      .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_decrypt(cfg_decrypt),
      .cfg_ready(cfg_ready), .key_ok(key_ok),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .aes_en(aes_en), .aes_key(aes_key), .aes_slt(aes_slt),
      .aes_din_valid(aes_din_valid), .aes_din(aes_din),
      .aes_rk_ready(aes_rk_ready), .aes_dout_valid(aes_dout_valid), .aes_dout(aes_dout),
      .err_ovf(err_ovf), .err_timeout(err_timeout)
   );

   function automatic logic [127:0] core_f(input logic [127:0] d);
      if (d == D1) return R1;
      if (d == D2) return R2;
      return {d[63:0], d[127:64]} ^ {4{32'hC3A55A3C}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkn(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Core stand-in: fixed-latency pipeline, rk_ready drops on aes_en and returns later.
   initial begin
      logic         pv [LAT];
      logic [127:0] pd [LAT];
      int rk_cnt;
      rk_cnt = 0;
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      forever begin
         @(negedge clk);
         if (!rstn) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
            if (core_on) aes_dout_valid = 1'b0;
            rk_cnt = 0;
         end else begin
            if (core_on) begin
               aes_dout_valid = pv[LAT-1];
               aes_dout       = pd[LAT-1];
            end
            for (int i = LAT-1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
            pv[0] = aes_din_valid;
            pd[0] = core_f(aes_din);
            if (aes_en) begin
               aes_rk_ready = 1'b0;
               rk_cnt = 6;
            end else if (rk_cnt > 0) begin
               rk_cnt--;
               if (rk_cnt == 0) aes_rk_ready = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (aes_en) en_cycles++;
   end

   // Monitor: every result the sink accepts must match the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rstn && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected none", m_data);
         end else begin
            check("m_data", m_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic send_block(input logic [127:0] data);
      bit done;
      done = 1'b0;
      s_valid = 1'b1;
      s_data  = data;
      for (int i = 0; i < 60 && !done; i++) begin
         if (s_ready) begin
            exp_q.push_back(core_f(data));
            done = 1'b1;
         end
         tick();
      end
      check1("send_accepted", done, 1'b1);
      if (done) begin
         check1("din_valid", aes_din_valid, 1'b1);
         check("din", aes_din, data);
      end
   endtask

   task automatic wait_q_empty(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      checkn(name, exp_q.size(), 0);
   endtask

   task automatic check_outputs_zero();
      check1("rst_cfg_ready", cfg_ready, 1'b0);
      check1("rst_key_ok", key_ok, 1'b0);
      check1("rst_s_ready", s_ready, 1'b0);
      check1("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, '0);
      check1("rst_aes_en", aes_en, 1'b0);
      check("rst_aes_key", aes_key, '0);
      check1("rst_aes_slt", aes_slt, 1'b0);
      check1("rst_din_valid", aes_din_valid, 1'b0);
      check("rst_aes_din", aes_din, '0);
      check1("rst_err_ovf", err_ovf, 1'b0);
      check1("rst_err_timeout", err_timeout, 1'b0);
   endtask

   task automatic wait_key_ok(input string name);
      for (int i = 0; i < 40 && !key_ok; i++) tick();
      check1(name, key_ok, 1'b1);
   endtask

   initial begin
      logic [127:0] data;
      int issued, bad;
      bit rk_prev, found;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      tick();
      check1("idle_cfg_ready", cfg_ready, 1'b1);

      // Key load
      cfg_key = KEY1; cfg_decrypt = 1'b0; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      check1("key_req_aes_en", aes_en, 1'b1);
      check("aes_key", aes_key, KEY1);
      check1("aes_slt_enc", aes_slt, 1'b0);
      check1("key_req_cfg_ready", cfg_ready, 1'b0);
      rk_prev = aes_rk_ready;
      bad = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         rk_prev = aes_rk_ready;
         if (cfg_ready) bad++;
         tick();
         found = key_ok;
      end
      check1("key_ok_after_rk", key_ok, 1'b1);
      check1("rk_ready_low_before_key_ok", rk_prev, 1'b0);
      check1("rk_ready_high_at_key_ok", aes_rk_ready, 1'b1);
      checkn("cfg_ready_during_key", bad, 0);
      checkn("aes_en_cycles", en_cycles, 1);
      check1("ready_cfg_ready", cfg_ready, 1'b1);

      // Two-block stream
      m_ready = 1'b1;
      send_block(D1);
      send_block(D2);
      s_valid = 1'b0;
      wait_q_empty("stream_drained", 60);
      check1("stream_err_ovf", err_ovf, 1'b0);

      // Credit limit
      m_ready = 1'b0;
      s_valid = 1'b1;
      data = 128'h1000_0000_0000_0000_0000_0000_0000_0000;
      issued = 0;
      for (int i = 0; i < 20; i++) begin
         s_data = data;
         if (s_ready) begin
            exp_q.push_back(core_f(data));
            issued++;
            data = data + 128'd1;
         end
         tick();
      end
      checkn("credit_issued", issued, 4);
      check1("credit_s_ready", s_ready, 1'b0);
      check1("credit_m_valid", m_valid, 1'b1);
      check1("credit_err_ovf", err_ovf, 1'b0);
      m_ready = 1'b1;
      send_block(data);
      send_block(data + 128'd1);
      s_valid = 1'b0;
      wait_q_empty("credit_drained", 80);
      check1("credit_err_ovf_end", err_ovf, 1'b0);

      // Re-key with two blocks in flight
      send_block(128'hAAAA_0000_0000_0000_0000_0000_0000_0001);
      send_block(128'hAAAA_0000_0000_0000_0000_0000_0000_0002);
      s_valid = 1'b0;
      cfg_key = KEY2; cfg_decrypt = 1'b1; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      s_valid = 1'b1;
      s_data = 128'hCCCC_0000_0000_0000_0000_0000_0000_0003;
      check1("drain_key_ok", key_ok, 1'b0);
      check1("drain_cfg_ready", cfg_ready, 1'b0);
      checkn("drain_pending", exp_q.size(), 2);
      bad = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (s_ready || aes_din_valid) bad++;
         tick();
         found = aes_en;
      end
      s_valid = 1'b0;
      check1("rekey_aes_en", aes_en, 1'b1);
      checkn("drain_no_issue", bad, 0);
      checkn("drain_delivered_before_en", exp_q.size(), 0);
      check1("rekey_slt", aes_slt, 1'b1);
      check("rekey_key", aes_key, KEY2);
      wait_key_ok("rekey_key_ok");
      checkn("rekey_en_cycles", en_cycles, 2);

      // Forced overflow
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_block(128'hBBBB_0000_0000_0000_0000_0000_0000_0000 + 128'(i));
      s_valid = 1'b0;
      repeat (12) tick();
      check1("ovf_full_m_valid", m_valid, 1'b1);
      check1("ovf_full_s_ready", s_ready, 1'b0);
      check1("ovf_before", err_ovf, 1'b0);
      core_on = 1'b0;
      aes_dout_valid = 1'b1;
      aes_dout = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      tick();
      aes_dout_valid = 1'b0;
      core_on = 1'b1;
      check1("ovf_flag", err_ovf, 1'b1);
      m_ready = 1'b1;
      wait_q_empty("ovf_contents", 40);
      tick();
      check1("ovf_no_extra", m_valid, 1'b0);
      check1("ovf_sticky", err_ovf, 1'b1);

      // Reset mid-stream
      m_ready = 1'b0;
      send_block(128'hEEEE_0000_0000_0000_0000_0000_0000_0001);
      send_block(128'hEEEE_0000_0000_0000_0000_0000_0000_0002);
      s_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      check_outputs_zero();
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (12) tick();
      check1("post_rst_cfg_ready", cfg_ready, 1'b1);
      check1("post_rst_m_valid", m_valid, 1'b0);
      check1("post_rst_err_ovf", err_ovf, 1'b0);
      check1("post_rst_key_ok", key_ok, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
